keypad_scanner: RTL and testbench

Matrix keypad scanner for the board's 4x4 keypad. It is the input-side counterpart of the multiplexed seven-segment driver: it drives one row low at a time, reads the active-low columns, debounces over whole scan frames, and reports one confirmed key code per press. It sits between the keypad pins and the counter/display logic, replacing single-button debounce where a keypad is fitted.

---
 rtl/keypad_scanner_if.sv | 20 ++
 rtl/keypad_scanner.sv | 195 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the decoded key outputs of keypad_scanner.
// master: the scanner; slave: the keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       multi_key;

    modport master (
        output row_n, key_code, key_valid, key_down, multi_key,
        input  col_n
    );

    modport slave (
        input  row_n, key_code, key_valid, key_down, multi_key,
        output col_n
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debounce and one code per press.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter logic [31:0] SCAN_CYCLES        = 32'd50_000,
    parameter logic [7:0]  DEBOUNCE_SCANS     = 8'd5,
    parameter logic [7:0]  REPEAT_DELAY_SCANS = 8'd125,
    parameter logic [7:0]  REPEAT_RATE_SCANS  = 8'd25
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    if (SCAN_CYCLES < 32'd4 || DEBOUNCE_SCANS < 8'd1 ||
        REPEAT_DELAY_SCANS == 8'd0 || REPEAT_RATE_SCANS == 8'd0) begin : g_bad_params
        $error("keypad_scanner: illegal parameter value");
    end

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_col_s1, r_col_s2;
    logic [31:0] r_dwell;
    logic [1:0]  r_row;
    logic [15:0] r_frame;
    logic        r_frame_end;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_cand, w_cand_nxt;
    logic [3:0]  r_code, w_code_nxt;
    logic        r_valid, w_valid_nxt, w_valid_final;
    logic        r_multi;
    logic [4:0]  w_nkeys;
    logic [3:0]  w_fcode;
    logic        w_single, w_empty, w_dwell_end;

    assign w_dwell_end = (r_dwell == SCAN_CYCLES - 32'd1);

    // Scan timing, column synchronizer and frame capture at the end of each row dwell
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col_s1    <= 4'hF;
            r_col_s2    <= 4'hF;
            r_dwell     <= '0;
            r_row       <= '0;
            r_frame     <= '0;
            r_frame_end <= 1'b0;
        end else begin
            r_col_s1    <= kp.col_n;
            r_col_s2    <= r_col_s1;
            r_frame_end <= w_dwell_end && (r_row == 2'd3);
            if (w_dwell_end) begin
                r_dwell                      <= '0;
                r_row                        <= r_row + 2'd1;
                r_frame[{r_row, 2'b00} +: 4] <= ~r_col_s2;
            end else begin
                r_dwell <= r_dwell + 32'd1;
            end
        end
    end

    // Frame bit 4r+c is key (r,c), so the bit index is the key code itself
    always_comb begin
        w_nkeys = '0;
        w_fcode = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_frame[i]) begin
                w_nkeys = w_nkeys + 5'd1;
                w_fcode = 4'(i);
            end
        end
    end

    assign w_single = (w_nkeys == 5'd1);
    assign w_empty  = (w_nkeys == 5'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        if (r_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_fcode;
                        w_cnt_nxt  = 8'd1;
                        if (DEBOUNCE_SCANS <= 8'd1) begin
                            w_state_nxt = S_PRESSED;
                            w_code_nxt  = w_fcode;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (w_single && (w_fcode == r_cand)) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                        if (r_cnt + 8'd1 >= DEBOUNCE_SCANS) begin
                            w_state_nxt = S_PRESSED;
                            w_code_nxt  = r_cand;
                            w_valid_nxt = 1'b1;
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_fcode;
                        w_cnt_nxt  = 8'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    // No rollover: any non-empty frame, even multi, keeps the key held
                    if (w_empty) begin
                        w_cnt_nxt   = 8'd1;
                        w_state_nxt = (DEBOUNCE_SCANS <= 8'd1) ? S_IDLE : S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (w_empty) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                        if (r_cnt + 8'd1 >= DEBOUNCE_SCANS) w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_PRESSED;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [7:0] r_rep_cnt, w_rep_cnt_nxt;
    logic       r_rep_armed, w_rep_armed_nxt;
    logic       w_rep_fire;

    // Repeat counter only runs across frames that both start and stay in PRESSED
    always_comb begin
        w_rep_cnt_nxt   = r_rep_cnt;
        w_rep_armed_nxt = r_rep_armed;
        w_rep_fire      = 1'b0;
        if (r_state != S_PRESSED || w_state_nxt != S_PRESSED) begin
            w_rep_cnt_nxt   = '0;
            w_rep_armed_nxt = 1'b0;
        end else if (r_frame_end) begin
            w_rep_cnt_nxt = r_rep_cnt + 8'd1;
            if (!r_rep_armed && (r_rep_cnt + 8'd1 == REPEAT_DELAY_SCANS)) begin
                w_rep_fire      = 1'b1;
                w_rep_cnt_nxt   = '0;
                w_rep_armed_nxt = 1'b1;
            end else if (r_rep_armed && (r_rep_cnt + 8'd1 == REPEAT_RATE_SCANS)) begin
                w_rep_fire    = 1'b1;
                w_rep_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else begin
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_armed <= w_rep_armed_nxt;
        end
    end

    assign w_valid_final = w_valid_nxt | w_rep_fire;
`else
    assign w_valid_final = w_valid_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_final;
            if (r_frame_end) r_multi <= (w_nkeys >= 5'd2);
        end
    end

    assign kp.row_n     = ~(4'b0001 << r_row);
    assign kp.key_code  = r_code;
    assign kp.key_valid = r_valid;
    assign kp.key_down  = (r_state == S_PRESSED) || (r_state == S_RELEASE);
    assign kp.multi_key = r_multi;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives columns, and a frame-level
// press/release model predicts pulses, key_code, key_down and multi_key.
module tb_keypad_scanner;
    localparam logic [31:0] SC = 32'd8;
    localparam logic [7:0]  DB = 8'd3;
`ifdef KEYPAD_REPEAT_EN
    localparam int RD = 4;
    localparam int RR = 2;
`else
    localparam int RD = 125;
    localparam int RR = 25;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys  = '0;
    logic [3:0]  w_col;
    int          checks = 0;
    int          errors = 0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_CYCLES       (SC),
        .DEBOUNCE_SCANS    (DB),
        .REPEAT_DELAY_SCANS(8'(RD)),
        .REPEAT_RATE_SCANS (8'(RR))
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    // Keypad: column c is pulled low when a closed key sits on a driven row
    always_comb begin
        w_col = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[4*r+c] && !kp.row_n[r]) w_col[c] = 1'b0;
    end
    assign kp.col_n = w_col;

    // Reference model state, advanced once per frame
    bit         m_held;
    int         m_run, m_empty, m_age;
    logic [3:0] m_cand, m_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_run = 0; m_empty = 0; m_age = 0;
        m_cand = '0;   m_code = '0;
    endtask

    task automatic model_frame(input logic [15:0] f, output int pulses);
        int         n;
        logic [3:0] code;
        n = $countones(f);
        code = '0;
        for (int i = 0; i < 16; i++) if (f[i]) code = 4'(i);
        pulses = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && code == m_cand) m_run++;
                else begin m_cand = code; m_run = 1; end
            end else begin
                m_run = 0;
            end
            if (m_run >= int'(DB)) begin
                m_held = 1'b1; m_code = m_cand; pulses = 1;
                m_run = 0; m_empty = 0; m_age = 0;
            end
        end else if (n == 0) begin
            m_empty++;
            if (m_empty >= int'(DB)) begin m_held = 1'b0; m_empty = 0; end
        end else if (m_empty > 0) begin
            m_empty = 0; m_age = 0;
        end else begin
            m_age++;
`ifdef KEYPAD_REPEAT_EN
            if (m_age >= RD && ((m_age - RD) % RR) == 0) pulses = 1;
`endif
        end
    endtask

    // Entered one cycle into a frame; returns one cycle into the next, just after its evaluation
    task automatic do_frame(input logic [15:0] f, input string tag);
        int pulses, seen;
        keys = f;
        seen = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (kp.key_valid) seen++;
        end
        model_frame(f, pulses);
        check({tag, "_pulses"}, 32'(seen), 32'(pulses));
        check({tag, "_valid_now"}, {31'd0, kp.key_valid}, 32'(pulses > 0));
        check({tag, "_down"}, {31'd0, kp.key_down}, {31'd0, m_held});
        check({tag, "_code"}, {28'd0, kp.key_code}, {28'd0, m_code});
        check({tag, "_multi"}, {31'd0, kp.multi_key}, 32'($countones(f) >= 2));
    endtask

    initial begin
        logic [3:0]  er;
        logic [15:0] f;
        int          sel, len;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_row", {28'd0, kp.row_n}, 32'hE);
        check("rst_outs", {25'd0, kp.key_code, kp.key_valid, kp.key_down, kp.multi_key}, 32'd0);
        reset = 1'b0;

        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            er = ~(4'b0001 << ((k / 8) % 4));
            check("idle_row", {28'd0, kp.row_n}, {28'd0, er});
            check("idle_outs", {25'd0, kp.key_code, kp.key_valid, kp.key_down, kp.multi_key}, 32'd0);
        end
        @(negedge clk);

        repeat (10) do_frame(16'h0200, "hold21");
        do_frame(16'h0000, "gap");
        repeat (2) do_frame(16'h0200, "reclose");
        repeat (4) do_frame(16'h0000, "release");
        repeat (2) do_frame(16'h0080, "bounce13");
        repeat (2) do_frame(16'h0000, "bounce_gap");
        repeat (2) do_frame(16'h8001, "multi");
        repeat (4) do_frame(16'h0001, "multi_open");

        // Asynchronous reset while PRESSED, checked before the next clock edge
        #2 reset = 1'b1;
        keys = '0;
        #1;
        check("async_rst_row", {28'd0, kp.row_n}, 32'hE);
        check("async_rst_outs", {25'd0, kp.key_code, kp.key_valid, kp.key_down, kp.multi_key}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        repeat (2) do_frame(16'h0000, "post_rst");

        repeat (12) do_frame(16'h0004, "hold02");
        repeat (4) do_frame(16'h0000, "rel02");

        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 5);
            f = '0;
            if (sel >= 3) f[$urandom_range(0, 15)] = 1'b1;
            if (sel >= 8) f[$urandom_range(0, 15)] = 1'b1;
            repeat (len) do_frame(f, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
